// File: rtl/celda_serial_deraizq.sv
// Serial LSB-first unsigned comparator: one bit pair per clock, reports A>B and A==B.
// Latency N+1 cycles from accepted start to done; start is ignored while not IDLE.
module celda_serial_deraizq #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N-1:0]         a,
    input  logic [N-1:0]         b,
    output logic                 busy,
    output logic                 done,
    output logic                 f,
    output logic                 f_eq,
    output logic [$clog2(N)-1:0] bit_idx
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   sh_a;
    logic [N-1:0]   sh_b;
    logic [CW-1:0]  cnt;
    logic           gt_mid;
    logic           eq_mid;
    logic           last_bit;
    logic           diff;
    logic           gt_upd;
    logic           eq_upd;

    // A differing pair overwrites gt_mid, so the most significant difference wins.
    assign last_bit = (cnt == CW'(N - 1));
    assign diff     = sh_a[0] ^ sh_b[0];
    assign gt_upd   = diff ? sh_a[0] : gt_mid;
    assign eq_upd   = eq_mid & ~diff;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            cnt    <= '0;
            gt_mid <= 1'b0;
            eq_mid <= 1'b1;
            f      <= 1'b0;
            f_eq   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a   <= a;
                        sh_b   <= b;
                        cnt    <= '0;
                        gt_mid <= 1'b0;
                        eq_mid <= 1'b1;
                    end
                end
                SHIFT: begin
                    sh_a   <= sh_a >> 1;
                    sh_b   <= sh_b >> 1;
                    gt_mid <= gt_upd;
                    eq_mid <= eq_upd;
                    if (last_bit) begin
                        f    <= gt_upd;
                        f_eq <= eq_upd;
                        cnt  <= '0;
                    end else begin
                        cnt  <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state == SHIFT);
    assign done    = (state == DONE);
    assign bit_idx = busy ? cnt : '0;
endmodule

// File: tb/tb_celda_serial_deraizq.sv
// Bench for celda_serial_deraizq: directed table, random operands vs arithmetic model, corner sequences.
module tb_celda_serial_deraizq;
    localparam int N  = 8;
    localparam int CW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;
    logic          busy;
    logic          done;
    logic          f;
    logic          f_eq;
    logic [CW-1:0] bit_idx;

    int checks = 0;
    int errors = 0;

    celda_serial_deraizq #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .f(f), .f_eq(f_eq), .bit_idx(bit_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] va;
        logic [N-1:0] vb;
        logic         exp_f;
        logic         exp_eq;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One full comparison from IDLE; operands are scrambled after capture.
    task automatic run_cmp(input logic [N-1:0] va, input logic [N-1:0] vb,
                           input logic exp_f, input logic exp_eq);
        a = va; b = vb; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            check("busy_in_shift", busy, 1);
            check("no_done_in_shift", done, 0);
            check("bit_idx", bit_idx, i);
            a = N'($urandom); b = N'($urandom);
            if (i == 2) start = 1'b1;
            step();
            start = 1'b0;
        end
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 0);
        check("f", f, exp_f);
        check("f_eq", f_eq, exp_eq);
        check("not_both", int'(f & f_eq), 0);
        step();
        check("done_one_cycle", done, 0);
        check("idle_not_busy", busy, 0);
        check("f_held", f, exp_f);
        check("f_eq_held", f_eq, exp_eq);
    endtask

    initial begin
        logic [N-1:0] ra, rb, cap_a, cap_b, last_a, last_b;
        logic         prev_busy;
        int           last_done, pulses, waited;

        vecs[0] = '{8'hA5, 8'h5A, 1'b1, 1'b0};
        vecs[1] = '{8'h3C, 8'h3C, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h7F, 1'b1, 1'b0};
        vecs[4] = '{8'h7F, 8'h80, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b0, 1'b1};

        // Reset then idle.
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_f", f, 0);
            check("rst_f_eq", f_eq, 0);
            check("rst_bit_idx", bit_idx, 0);
            step();
        end

        foreach (vecs[i]) run_cmp(vecs[i].va, vecs[i].vb, vecs[i].exp_f, vecs[i].exp_eq);

        // Random operands against plain arithmetic; some forced equal.
        for (int i = 0; i < 20; i++) begin
            ra = N'($urandom);
            rb = (i % 5 == 0) ? ra : N'($urandom);
            run_cmp(ra, rb, ra > rb, ra == rb);
        end

        // Reset mid-SHIFT aborts without a done pulse.
        a = 8'hFF; b = 8'h00; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("abort_bit_idx", bit_idx, 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_f", f, 0);
        check("abort_f_eq", f_eq, 0);
        pulses = 0;
        for (int i = 0; i < N + 3; i++) begin
            if (done) pulses++;
            step();
        end
        check("abort_no_done", pulses, 0);
        run_cmp(8'h12, 8'h11, 1'b1, 1'b0);

        // Start held high with operands changing every cycle.
        last_a = N'($urandom); last_b = N'($urandom);
        a = last_a; b = last_b; start = 1'b1;
        prev_busy = 1'b0; cap_a = '0; cap_b = '0;
        last_done = -1; pulses = 0; waited = 0;
        while (pulses < 3 && waited < 100) begin
            step();
            waited++;
            if (busy && !prev_busy) begin
                cap_a = last_a; cap_b = last_b;
                if (last_done >= 0) check("accept_after_done", waited - last_done, 2);
            end
            if (done) begin
                check("held_f", f, int'(cap_a > cap_b));
                check("held_f_eq", f_eq, int'(cap_a == cap_b));
                if (last_done >= 0) check("done_gap", waited - last_done, N + 2);
                last_done = waited;
                pulses++;
            end
            prev_busy = busy;
            last_a = N'($urandom); last_b = N'($urandom);
            a = last_a; b = last_b;
        end
        start = 1'b0;
        check("held_pulse_count", pulses, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
